aes_spram_dma: RTL and testbench

Block-transfer engine between the 64 KB on-chip SPRAM and the AES coprocessor core. It sits directly upstream and downstream of the SPRAM data port. It reads 128-bit blocks (four 32-bit words) from a source region, hands each block to the AES core over a valid/ready handshake, and writes each result back to a destination region. The CPU programs it through the coprocessor register file and polls `busy` or takes `done` as an interrupt.

---
 rtl/aes_dma_pkg.sv | 24 ++
 rtl/aes_dma_blkbuf.sv | 30 +++
 rtl/aes_spram_dma.sv | 154 +++++++++++++++
 tb/tb_aes_spram_dma.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_dma_pkg.sv
// Shared types and block/word mapping for the SPRAM <-> AES block-transfer engine.
package aes_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  localparam int BLOCK_WORDS = 4;

  // Word 0 (lowest address) occupies the most significant 32 bits of a block.
  function automatic int word_lsb(input logic [1:0] idx);
    return (BLOCK_WORDS - 1 - int'(idx)) * 32;
  endfunction

  function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] idx);
    return blk[word_lsb(idx) +: 32];
  endfunction

endpackage

// File: rtl/aes_dma_blkbuf.sv
// 128-bit block register: word loads from SPRAM, full loads from the AES core,
// and a word-indexed read port for writeback.
module aes_dma_blkbuf
  import aes_dma_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [1:0]   wr_idx,
  input  logic [31:0]  wr_word,
  input  logic         ld_en,
  input  logic [127:0] ld_blk,
  input  logic [1:0]   rd_idx,
  output logic [31:0]  rd_word,
  output logic [127:0] blk
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk <= '0;
    end else if (ld_en) begin
      blk <= ld_blk;
    end else if (wr_en) begin
      blk[word_lsb(wr_idx) +: 32] <= wr_word;
    end
  end

  assign rd_word = word_of(blk, rd_idx);

endmodule

// File: rtl/aes_spram_dma.sv
// Block-transfer engine: reads 4-word blocks from SPRAM, passes them through the
// AES core over valid/ready, and writes the results back to a destination region.
module aes_spram_dma
  import aes_dma_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int NBLK_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [NBLK_W-1:0] nblocks,
  output logic              busy,
  output logic              done,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              aes_in_valid,
  input  logic              aes_in_ready,
  output logic [127:0]      aes_in_data,
  input  logic              aes_out_valid,
  output logic              aes_out_ready,
  input  logic [127:0]      aes_out_data
);

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [NBLK_W-1:0] remaining;
  logic [2:0]        k;

  logic              buf_wr;
  logic [1:0]        buf_wr_idx;
  logic              buf_ld;
  logic [1:0]        buf_rd_idx;
  logic [31:0]       buf_rd_word;

  // Read data for the address presented at k-1 arrives at k, so capture lags by one.
  assign buf_wr     = (state == S_READ) && (k != 3'd0);
  assign buf_wr_idx = 2'(k - 3'd1);
  assign buf_ld     = (state == S_WAIT) && aes_out_valid;
  assign buf_rd_idx = 2'(k + 3'd1);

  aes_dma_blkbuf u_blkbuf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (buf_wr),
    .wr_idx  (buf_wr_idx),
    .wr_word (mem_rdata),
    .ld_en   (buf_ld),
    .ld_blk  (aes_out_data),
    .rd_idx  (buf_rd_idx),
    .rd_word (buf_rd_word),
    .blk     (aes_in_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      src           <= '0;
      dst           <= '0;
      remaining     <= '0;
      k             <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_wen       <= 4'h0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      aes_in_valid  <= 1'b0;
      aes_out_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            src       <= src_addr;
            dst       <= dst_addr;
            remaining <= nblocks;
            k         <= '0;
            if (nblocks == '0) begin
              state <= S_DONE;
            end else begin
              state    <= S_READ;
              busy     <= 1'b1;
              mem_addr <= src_addr;
            end
          end
        end

        S_READ: begin
          if (k == 3'd4) begin
            state        <= S_SEND;
            aes_in_valid <= 1'b1;
          end else begin
            k <= k + 3'd1;
            if (k != 3'd3) mem_addr <= src + ADDR_W'(k + 3'd1);
          end
        end

        S_SEND: begin
          if (aes_in_ready) begin
            aes_in_valid  <= 1'b0;
            aes_out_ready <= 1'b1;
            state         <= S_WAIT;
          end
        end

        // The block buffer loads on this same edge, so word 0 comes straight from the core.
        S_WAIT: begin
          if (aes_out_valid) begin
            aes_out_ready <= 1'b0;
            state         <= S_WRITE;
            k             <= '0;
            mem_wen       <= 4'hF;
            mem_addr      <= dst;
            mem_wdata     <= word_of(aes_out_data, 2'd0);
          end
        end

        S_WRITE: begin
          if (k == 3'd3) begin
            mem_wen   <= 4'h0;
            src       <= src + ADDR_W'(BLOCK_WORDS);
            dst       <= dst + ADDR_W'(BLOCK_WORDS);
            remaining <= remaining - NBLK_W'(1);
            k         <= '0;
            if (remaining == NBLK_W'(1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
            end else begin
              state    <= S_READ;
              mem_addr <= src + ADDR_W'(BLOCK_WORDS);
            end
          end else begin
            k         <= k + 3'd1;
            mem_addr  <= dst + ADDR_W'(k + 3'd1);
            mem_wdata <= buf_rd_word;
          end
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spram_dma.sv
// Scoreboard bench for aes_spram_dma: SPRAM model, AES stub, and a reference
// model that predicts AES inputs, memory writes and done pulses per transfer.
module tb_aes_spram_dma;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [13:0]  src_addr, dst_addr;
  logic [11:0]  nblocks;
  logic         busy, done;
  logic [3:0]   mem_wen;
  logic [13:0]  mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         aes_in_valid, aes_in_ready;
  logic [127:0] aes_in_data;
  logic         aes_out_valid, aes_out_ready;
  logic [127:0] aes_out_data;

  aes_spram_dma dut (
    .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .nblocks(nblocks), .busy(busy), .done(done), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .aes_in_valid(aes_in_valid),
    .aes_in_ready(aes_in_ready), .aes_in_data(aes_in_data), .aes_out_valid(aes_out_valid),
    .aes_out_ready(aes_out_ready), .aes_out_data(aes_out_data)
  );

  always #5 clk = ~clk;

  typedef struct { logic [13:0] a; logic [31:0] d; } wr_t;

  int           checks = 0;
  int           failures = 0;
  int           done_cnt = 0;
  wr_t          exp_w[$];
  logic [127:0] exp_in[$];
  int           exp_done[$];
  logic [13:0]  touched[$];

  logic [31:0]  mem [0:16383];
  logic [31:0]  ref_mem [0:16383];
  logic         poke_en = 1'b0;
  logic [13:0]  poke_addr = '0;
  logic [31:0]  poke_data = '0;

  int           aes_mode = 0;
  int           aes_lat = 1;
  int           aes_stall = 0;

  task automatic check(input bit ok, input string name, input logic [127:0] act,
                       input logic [127:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // SPRAM: one-cycle read latency, full-word writes.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (mem_wen == 4'hF) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // AES stub: optional input stall, fixed latency, identity or bitwise invert.
  initial begin
    logic [127:0] held;
    aes_in_ready  = 1'b0;
    aes_out_valid = 1'b0;
    aes_out_data  = '0;
    forever begin
      @(posedge clk); #1;
      if (aes_in_valid && !rst) begin
        for (int i = 0; i < aes_stall; i++) begin @(posedge clk); #1; end
        held = aes_in_data;
        aes_in_ready = 1'b1;
        @(posedge clk); #1;
        aes_in_ready = 1'b0;
        for (int i = 1; i < aes_lat; i++) begin @(posedge clk); #1; end
        aes_out_data  = (aes_mode != 0) ? ~held : held;
        aes_out_valid = 1'b1;
        while (!aes_out_ready) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        aes_out_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output event.
  logic         prev_pend = 1'b0;
  logic [127:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend)
        check(aes_in_valid && (aes_in_data === prev_data), "aes_in_stable", aes_in_data, prev_data);
      prev_pend = aes_in_valid && !aes_in_ready;
      prev_data = aes_in_data;
      if (aes_in_valid && aes_in_ready) begin
        if (exp_in.size() == 0) check(1'b0, "unexpected_aes_in", aes_in_data, 0);
        else begin
          logic [127:0] e;
          e = exp_in.pop_front();
          check(aes_in_data === e, "aes_in_data", aes_in_data, e);
        end
      end
      if (mem_wen != 4'h0) begin
        check(mem_wen == 4'hF, "mem_wen", mem_wen, 4'hF);
        if (exp_w.size() == 0) check(1'b0, "unexpected_write", mem_addr, 0);
        else begin
          wr_t e;
          e = exp_w.pop_front();
          check(mem_addr === e.a, "wr_addr", mem_addr, e.a);
          check(mem_wdata === e.d, "wr_data", mem_wdata, e.d);
        end
      end
      if (done) begin
        done_cnt++;
        check(!busy, "busy_at_done", busy, 0);
        if (exp_done.size() == 0) check(1'b0, "unexpected_done", done, 0);
        else void'(exp_done.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [13:0] a, input logic [31:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    ref_mem[a] = d;
    touched.push_back(a);
    tick();
    poke_en = 1'b0;
  endtask

  // Reference model: blocks processed in order, each read fully before written.
  task automatic issue(input logic [13:0] s, input logic [13:0] d, input int n,
                       input int mode, input int maxw, input bit want_done);
    int nw = 0;
    for (int b = 0; b < n; b++) begin
      logic [127:0] blk, res;
      logic [13:0]  sa, da;
      for (int i = 0; i < 4; i++) begin
        sa = s + 14'(4 * b + i);
        blk[127 - 32 * i -: 32] = ref_mem[sa];
      end
      exp_in.push_back(blk);
      res = (mode != 0) ? ~blk : blk;
      for (int i = 0; i < 4; i++) begin
        da = d + 14'(4 * b + i);
        if (nw < maxw) begin
          exp_w.push_back('{a: da, d: res[127 - 32 * i -: 32]});
          ref_mem[da] = res[127 - 32 * i -: 32];
          touched.push_back(da);
          nw++;
        end
      end
    end
    if (want_done) exp_done.push_back(n);
  endtask

  task automatic pulse_start(input logic [13:0] s, input logic [13:0] d, input int n);
    src_addr = s; dst_addr = d; nblocks = 12'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int c0 = done_cnt;
    int i = 0;
    while (done_cnt == c0 && i < budget) begin tick(); i++; end
    check(done_cnt != c0, name, 0, 1);
  endtask

  task automatic check_end(input string name);
    int bad = 0;
    foreach (touched[i]) if (mem[touched[i]] !== ref_mem[touched[i]]) bad++;
    check(bad == 0, name, bad, 0);
    check(exp_w.size() == 0 && exp_in.size() == 0 && exp_done.size() == 0,
          "queues_drained", exp_w.size() + exp_in.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(busy == 1'b0, {tag, "_busy"}, busy, 0);
    check(done == 1'b0, {tag, "_done"}, done, 0);
    check(mem_wen == 4'h0, {tag, "_mem_wen"}, mem_wen, 0);
    check(mem_addr == 14'h0, {tag, "_mem_addr"}, mem_addr, 0);
    check(mem_wdata == 32'h0, {tag, "_mem_wdata"}, mem_wdata, 0);
    check(aes_in_valid == 1'b0, {tag, "_aes_in_valid"}, aes_in_valid, 0);
    check(aes_out_ready == 1'b0, {tag, "_aes_out_ready"}, aes_out_ready, 0);
    check(aes_in_data == 128'h0, {tag, "_aes_in_data"}, aes_in_data, 0);
  endtask

  initial begin
    logic [31:0] sb [4];
    logic [13:0] s, d;
    int n, c0;
    sb[0] = 32'h00112233; sb[1] = 32'h44556677; sb[2] = 32'h8899AABB; sb[3] = 32'hCCDDEEFF;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; nblocks = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Single block, identity, latency 3.
    for (int i = 0; i < 4; i++) poke(14'h10 + 14'(i), sb[i]);
    aes_mode = 0; aes_lat = 3; aes_stall = 0;
    c0 = done_cnt;
    issue(14'h10, 14'h20, 1, 0, 4, 1'b1);
    pulse_start(14'h10, 14'h20, 1);
    check(busy == 1'b1, "busy_after_start", busy, 1);
    wait_done(200, "single_done");
    repeat (3) tick();
    for (int i = 0; i < 4; i++) check(mem[14'h20 + 14'(i)] === sb[i], "single_dst_word", mem[14'h20 + 14'(i)], sb[i]);
    check(done_cnt - c0 == 1, "single_done_count", done_cnt - c0, 1);
    check_end("single_mem");

    // nblocks == 0: done on the second cycle after start, no activity.
    issue(14'h30, 14'h40, 0, 0, 0, 1'b1);
    pulse_start(14'h30, 14'h40, 0);
    check(done == 1'b0 && busy == 1'b0, "zero_cycle1", {done, busy}, 0);
    tick();
    check(done == 1'b1 && busy == 1'b0, "zero_cycle2", {done, busy}, 2'b10);
    tick();
    check(done == 1'b0, "zero_cycle3", done, 0);
    repeat (3) tick();
    check_end("zero_mem");

    // Wrap-around source.
    for (int i = 0; i < 4; i++) poke(14'h3FFE + 14'(i), $urandom);
    aes_mode = 1; aes_lat = 1; aes_stall = 0;
    issue(14'h3FFE, 14'h200, 1, 1, 4, 1'b1);
    pulse_start(14'h3FFE, 14'h200, 1);
    wait_done(200, "wrap_done");
    repeat (2) tick();
    check_end("wrap_mem");

    // In-place with input backpressure.
    for (int i = 0; i < 12; i++) poke(14'h100 + 14'(i), $urandom);
    aes_mode = 1; aes_lat = 2; aes_stall = 5;
    issue(14'h100, 14'h100, 3, 1, 12, 1'b1);
    pulse_start(14'h100, 14'h100, 3);
    wait_done(600, "inplace_done");
    repeat (2) tick();
    check_end("inplace_mem");

    // Start while busy must be dropped.
    for (int i = 0; i < 8; i++) poke(14'h400 + 14'(i), $urandom);
    for (int i = 0; i < 4; i++) poke(14'h600 + 14'(i), $urandom);
    for (int i = 0; i < 4; i++) poke(14'h700 + 14'(i), $urandom);
    aes_mode = 0; aes_lat = 2; aes_stall = 1;
    issue(14'h400, 14'h500, 2, 0, 8, 1'b1);
    pulse_start(14'h400, 14'h500, 2);
    repeat (6) tick();
    pulse_start(14'h600, 14'h700, 1);
    wait_done(600, "busy_start_done");
    repeat (30) tick();
    check_end("busy_start_mem");

    // Randomized transfers.
    for (int t = 0; t < 4; t++) begin
      s = 14'($urandom); d = 14'($urandom); n = $urandom_range(1, 3);
      aes_mode = $urandom_range(0, 1); aes_lat = $urandom_range(1, 4); aes_stall = $urandom_range(0, 3);
      for (int i = 0; i < 4 * n; i++) poke(d + 14'(i), $urandom);
      for (int i = 0; i < 4 * n; i++) poke(s + 14'(i), $urandom);
      issue(s, d, n, aes_mode, 4 * n, 1'b1);
      pulse_start(s, d, n);
      wait_done(800, "rand_done");
      repeat (2) tick();
      check_end("rand_mem");
    end

    // Reset during WRITE after two words have been committed.
    for (int i = 0; i < 4; i++) poke(14'h800 + 14'(i), $urandom);
    for (int i = 0; i < 4; i++) poke(14'h900 + 14'(i), $urandom);
    aes_mode = 1; aes_lat = 1; aes_stall = 0;
    c0 = done_cnt;
    issue(14'h800, 14'h900, 1, 1, 2, 1'b0);
    pulse_start(14'h800, 14'h900, 1);
    begin
      bit hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
        tick();
        if (mem_wen == 4'hF && mem_addr == 14'h902) hit = 1'b1;
      end
      check(hit, "reach_third_write", hit, 1);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(); tick();
    rst = 1'b0;
    repeat (20) tick();
    check(done_cnt == c0, "midrst_no_done", done_cnt - c0, 0);
    check_end("midrst_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
